// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - format codes, opcodes and instruction-to-immediate decode
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_t;

    localparam int MAX_XLEN = 64;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_32  = 7'b0111011;

    typedef struct packed {
        fmt_t                fmt;
        logic [MAX_XLEN-1:0] imm;
    } dec_t;

    // Immediate is produced at the widest XLEN; the low XLEN bits are the
    // correctly sign-extended value for any narrower core.
    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t d;
        logic s;
        s     = instr[31];
        d.fmt = FMT_ILL;
        d.imm = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                d.fmt = FMT_I;
                d.imm = {{52{s}}, instr[31:20]};
            end
            OPC_STORE: begin
                d.fmt = FMT_S;
                d.imm = {{52{s}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                d.fmt = FMT_B;
                d.imm = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                d.fmt = FMT_U;
                d.imm = {{32{s}}, instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                d.fmt = FMT_J;
                d.imm = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP, OPC_OP_32: begin
                d.fmt = FMT_R;
            end
            default: begin
                d.fmt = FMT_ILL;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_fifo.sv
// rtl/imm_fifo.sv - generic synchronous FIFO with flush and full/empty flags
module imm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // Extra MSB on each pointer separates full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign rd_en = pop && !empty && !flush;
    assign wr_en = push && !flush && (!full || rd_en);

    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate decode with output FIFO and illegal counter
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int EW = XLEN + 4;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    dec_t          dec;
    logic          dec_illegal;
    logic          dec_unused;
    logic [EW-1:0] wdata;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign dec         = decode_instr(in_instr);
    assign dec_illegal = (dec.fmt == FMT_ILL);
    assign dec_unused  = ^dec.imm;
    assign wdata       = {dec_illegal, dec.fmt, dec.imm[XLEN-1:0]};

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign in_ready  = !full || pop || flush;
    // A word offered during flush is dropped, so it is neither stored nor counted.
    assign push      = in_valid && in_ready && !flush;

    imm_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .push (push),
        .wdata(wdata),
        .pop  (pop),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    assign out_imm     = empty ? '0 : head[XLEN-1:0];
    assign out_fmt     = empty ? 3'd0 : head[XLEN+2:XLEN];
    assign out_illegal = empty ? 1'b0 : head[XLEN+3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (push && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - randomized self-checking bench against a queue reference model
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [1:0]  illegal_cnt;

    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_in_instr;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic        b_out_illegal;
    logic [15:0] b_illegal_cnt;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    imm_decode_stage #(.XLEN(64), .DEPTH(4), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .illegal_cnt(b_illegal_cnt)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t       q[$];
    logic [1:0] exp_cnt;
    logic       exp_rdy;
    logic       obs_rdy;
    int         errors = 0;
    int         checks = 0;

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t   e;
        longint v;
        v     = 0;
        e.ill = 1'b0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin e.fmt = 3'd1; v = $signed(w[31:20]); end
            7'h23: begin e.fmt = 3'd2; v = $signed({w[31:25], w[11:7]}); end
            7'h63: begin e.fmt = 3'd3; v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); end
            7'h37, 7'h17: begin e.fmt = 3'd4; v = $signed({w[31:12], 12'h000}); end
            7'h6F: begin e.fmt = 3'd5; v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}); end
            7'h33, 7'h3B: begin e.fmt = 3'd0; v = 0; end
            default: begin e.fmt = 3'd7; e.ill = 1'b1; v = 0; end
        endcase
        e.imm = v;
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 12))
            0: w[6:0] = 7'h13;
            1: w[6:0] = 7'h03;
            2: w[6:0] = 7'h67;
            3: w[6:0] = 7'h73;
            4: w[6:0] = 7'h23;
            5: w[6:0] = 7'h63;
            6: w[6:0] = 7'h37;
            7: w[6:0] = 7'h17;
            8: w[6:0] = 7'h6F;
            9: w[6:0] = 7'h33;
            10: w[6:0] = 7'h3B;
            11: w[6:0] = 7'h7F;
            default: ;
        endcase
        return w;
    endfunction

    // Drives one cycle on dut32 and advances the reference model; no checking here.
    task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
        exp_t e;
        in_valid  = v;
        in_instr  = w;
        out_ready = ordy;
        flush     = fl;
        exp_rdy   = fl || (q.size() < 2) || ordy;
        #1;
        obs_rdy = in_ready;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && exp_rdy) begin
                e = ref_decode(w);
                q.push_back(e);
                if (e.ill && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        exp_cnt = 2'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_instr = 0; out_ready = 0; flush = 0;
        b_in_valid = 0; b_in_instr = 0; b_out_ready = 0; b_flush = 0;
        rst_n = 1'b0;
        q.delete();
        exp_cnt = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
        if (out_valid !== 1'b0) errors++;
        checks++; if ({out_imm, out_fmt, out_illegal} !== 36'd0) begin errors++; $display("FAIL reset_fields got=%h want=0", {out_imm, out_fmt, out_illegal}); end
        checks++; if (illegal_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", illegal_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (b_out_valid !== 1'b0 || b_out_imm !== 64'd0) begin errors++; $display("FAIL reset_dut64 got=%b/%h want=0/0", b_out_valid, b_out_imm); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b want=1", out_valid); end
        checks++; if (out_imm !== 32'hFFFFFFFF || out_fmt !== 3'd1 || out_illegal !== 1'b0) begin
            errors++; $display("FAIL addi_fields got=%h/%0d/%b want=ffffffff/1/0", out_imm, out_fmt, out_illegal);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || out_imm !== 32'd0) begin errors++; $display("FAIL addi_drain got=%b/%h want=0/0", out_valid, out_imm); end
    endtask

    task automatic test_sequence();
        logic [31:0] words [3];
        logic [31:0] imms  [3];
        logic [2:0]  fmts  [3];
        words = '{32'hFE112E23, 32'h123452B7, 32'hFE000EE3};
        imms  = '{32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFFC};
        fmts  = '{3'd2, 3'd4, 3'd3};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, words[i], 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b1 || out_imm !== imms[i] || out_fmt !== fmts[i] || out_illegal !== 1'b0) begin
                errors++; $display("FAIL seq_%0d got=%b/%h/%0d want=1/%h/%0d", i, out_valid, out_imm, out_fmt, imms[i], fmts[i]);
            end
            checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL seq_ready_%0d got=%b want=1", i, obs_rdy); end
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        step(1'b1, rand_word(), 1'b0, 1'b0);
        step(1'b1, rand_word(), 1'b0, 1'b0);
        step(1'b1, rand_word(), 1'b0, 1'b0);
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b want=0", obs_rdy); end
        checks++; if (q.size() != 2 || out_valid !== 1'b1 || out_imm !== q[0].imm[31:0]) begin
            errors++; $display("FAIL bp_head got=%b/%h want=1/%h", out_valid, out_imm, q[0].imm[31:0]);
        end
        for (int i = 0; i < 60; i++) begin
            if (i < 20) step(1'b1, rand_word(), 1'b1, 1'b0);
            else if (i < 50) step(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)), 1'b0);
            else step(1'b0, 32'h0, 1'b1, 1'b0);
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL bp_ready_%0d got=%b want=%b", i, obs_rdy, exp_rdy); end
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL bp_valid_%0d got=%b want=%b", i, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if ({out_illegal, out_fmt, out_imm} !== {q[0].ill, q[0].fmt, q[0].imm[31:0]}) begin
                    errors++; $display("FAIL bp_data_%0d got=%b/%0d/%h want=%b/%0d/%h", i, out_illegal, out_fmt, out_imm, q[0].ill, q[0].fmt, q[0].imm[31:0]);
                end
            end
            checks++; if (illegal_cnt !== exp_cnt) begin errors++; $display("FAIL bp_cnt_%0d got=%0d want=%0d", i, illegal_cnt, exp_cnt); end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        step(1'b1, 32'h0000007F, 1'b1, 1'b0);
        checks++; if (out_illegal !== 1'b1 || out_imm !== 32'd0 || out_fmt !== 3'd7) begin
            errors++; $display("FAIL ill_fields got=%b/%h/%0d want=1/0/7", out_illegal, out_imm, out_fmt);
        end
        step(1'b1, 32'h0000007F, 1'b1, 1'b0);
        checks++; if (illegal_cnt !== 2'd2) begin errors++; $display("FAIL ill_cnt2 got=%0d want=2", illegal_cnt); end
        repeat (3) step(1'b1, 32'h0000007F, 1'b1, 1'b0);
        checks++; if (illegal_cnt !== 2'd3) begin errors++; $display("FAIL ill_sat got=%0d want=3", illegal_cnt); end
        step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        checks++; if (illegal_cnt !== 2'd3 || out_illegal !== 1'b0) begin errors++; $display("FAIL ill_hold got=%0d/%b want=3/0", illegal_cnt, out_illegal); end
        step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_xlen64();
        exp_t        e;
        logic [31:0] w;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_instr  = 32'hFFF00093;
        @(posedge clk); #1;
        checks++; if (b_out_valid !== 1'b1 || b_out_imm !== 64'hFFFFFFFFFFFFFFFF || b_out_fmt !== 3'd1) begin
            errors++; $display("FAIL x64_addi got=%b/%h/%0d want=1/ffffffffffffffff/1", b_out_valid, b_out_imm, b_out_fmt);
        end
        b_in_instr = 32'h800002B7;
        @(posedge clk); #1;
        checks++; if (b_out_imm !== 64'hFFFFFFFF80000000 || b_out_fmt !== 3'd4) begin
            errors++; $display("FAIL x64_lui got=%h/%0d want=ffffffff80000000/4", b_out_imm, b_out_fmt);
        end
        for (int i = 0; i < 16; i++) begin
            w = rand_word();
            e = ref_decode(w);
            b_in_instr = w;
            @(posedge clk); #1;
            checks++; if ({b_out_illegal, b_out_fmt, b_out_imm} !== {e.ill, e.fmt, e.imm}) begin
                errors++; $display("FAIL x64_rand_%0d word=%h got=%b/%0d/%h want=%b/%0d/%h", i, w, b_out_illegal, b_out_fmt, b_out_imm, e.ill, e.fmt, e.imm);
            end
        end
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL x64_drain got=%b want=0", b_out_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] w;
        do_reset();
        step(1'b1, rand_word(), 1'b0, 1'b0);
        step(1'b1, 32'h0000007F, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_fill got=%b/%b want=1/0", out_valid, in_ready); end
        step(1'b1, 32'hFFF00093, 1'b0, 1'b1);
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b want=1", obs_rdy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got=%b want=0", out_valid); end
        checks++; if (illegal_cnt !== exp_cnt) begin errors++; $display("FAIL flush_cnt got=%0d want=%0d", illegal_cnt, exp_cnt); end
        w = 32'h123452B7;
        step(1'b1, w, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'h12345000) begin errors++; $display("FAIL flush_after got=%b/%h want=1/12345000", out_valid, out_imm); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'h0000007F, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || illegal_cnt === 2'd0) begin errors++; $display("FAIL areset_pre got=%b/%0d want=1/nonzero", out_valid, illegal_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || illegal_cnt !== 2'd0) begin errors++; $display("FAIL areset_now got=%b/%0d want=0/0", out_valid, illegal_cnt); end
        checks++; if (in_ready !== 1'b1 || out_imm !== 32'd0) begin errors++; $display("FAIL areset_ready got=%b/%h want=1/0", in_ready, out_imm); end
        q.delete();
        exp_cnt = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'hFE112E23, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFC || out_fmt !== 3'd2) begin
            errors++; $display("FAIL areset_resume got=%b/%h/%0d want=1/fffffffc/2", out_valid, out_imm, out_fmt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_backpressure();
        test_illegal();
        test_xlen64();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
